// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and its 4-bit ALU:
// widths, opcode encodings, FSM state encoding and a small flag helper.
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int RES_W  = DATA_W + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam int OP_W   = 3;
   localparam int SEL_W  = 2;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
   localparam logic [OP_W-1:0] OP_LOAD = 3'b100;
   localparam logic [OP_W-1:0] OP_CLR  = 3'b101;
   localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
   localparam logic [OP_W-1:0] OP_NOP  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   // Zero flag of an accumulator value.
   function automatic logic is_zero(input logic [DATA_W-1:0] v);
      return (v == '0);
   endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. The 5-bit result carries the ADD carry-out or
// the SUB borrow in its top bit; logic ops leave the top bit clear.
module alu_4bit
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SEL_W-1:0]  sel,
   output logic [RES_W-1:0]  result
);

   // Select the operation; subtraction wraps modulo 32 so a borrow sets bit 4.
   always_comb begin
      result = '0;
      case (sel)
         2'b00:   result = {1'b0, a & b};
         2'b01:   result = {1'b0, a | b};
         2'b10:   result = {1'b0, a} + {1'b0, b};
         default: result = {1'b0, a} - {1'b0, b};
      endcase
   end

endmodule

// File: rtl/alu_acc_seq.sv
// Command sequencer and accumulator in front of alu_4bit. Takes one
// opcode/operand command at a time, updates a 4-bit accumulator through the
// ALU (or through an inline shift-add multiplier for MUL) and returns the
// accumulator with zero/carry flags over a response handshake.
module alu_acc_seq
   import alu_pkg::*;
#(
   parameter int MUL_STEPS = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_operand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_acc,
   output logic              out_zero,
   output logic              out_carry
);

   localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

   state_t              state;
   state_t              state_nxt;
   logic                accept;

   logic [OP_W-1:0]     op_q;
   logic [DATA_W-1:0]   operand_q;
   logic [DATA_W-1:0]   acc;
   logic                carry;

   logic [STEP_W-1:0]   step;
   logic [PROD_W-1:0]   prod;
   logic [PROD_W-1:0]   partial;
   logic [PROD_W-1:0]   prod_sum;
   logic                mul_last;

   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [SEL_W-1:0]    alu_sel;
   logic [RES_W-1:0]    alu_result;

   logic [DATA_W-1:0]   exec_acc;
   logic                exec_carry;

   assign accept   = in_valid & in_ready;
   assign mul_last = (state == ST_MUL) && (step == LAST_STEP);

   alu_4bit u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .sel    (alu_sel),
      .result (alu_result)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state: one command in flight, response must be taken before the next accept.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = (in_op == OP_MUL) ? ST_MUL : ST_EXEC;
         ST_EXEC: state_nxt = ST_RESP;
         ST_MUL:  if (step == LAST_STEP) state_nxt = ST_RESP;
         ST_RESP: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake strobes and the ALU operand drive.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_RESP);
      alu_a     = acc;
      alu_b     = operand_q;
      alu_sel   = op_q[SEL_W-1:0];
   end

   // Capture the command on accept; held for the whole execution.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q      <= in_op;
         operand_q <= in_operand;
      end
   end

   // Shift-add step counter, restarted with every accepted command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               step <= '0;
      else if (accept)          step <= '0;
      else if (state == ST_MUL) step <= step + 1'b1;
   end

   // Partial product for the current multiplier bit, summed into the running product.
   always_comb begin
      partial  = operand_q[step] ? (PROD_W'(acc) << step) : '0;
      prod_sum = prod + partial;
   end

   // Running product; the multiplicand is acc, which stays put until the last step.
   always_ff @(posedge clk) begin
      if (accept)               prod <= '0;
      else if (state == ST_MUL) prod <= prod_sum;
   end

   // Single-cycle command result: ALU ops, LOAD, CLR and NOP.
   always_comb begin
      exec_acc   = acc;
      exec_carry = 1'b0;
      case (op_q)
         OP_AND, OP_OR: exec_acc = alu_result[DATA_W-1:0];
         OP_ADD, OP_SUB: begin
            exec_acc   = alu_result[DATA_W-1:0];
            exec_carry = alu_result[DATA_W];
         end
         OP_LOAD: exec_acc = operand_q;
         OP_CLR:  exec_acc = '0;
         default: exec_acc = acc;
      endcase
   end

   // Accumulator and carry: updated in EXEC or on the final multiply step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (state == ST_EXEC) begin
         acc   <= exec_acc;
         carry <= exec_carry;
      end else if (mul_last) begin
         acc   <= prod_sum[DATA_W-1:0];
         carry <= |prod_sum[PROD_W-1:DATA_W];
      end
   end

   // Response fields come straight from the registered accumulator.
   always_comb begin
      out_acc   = acc;
      out_zero  = is_zero(acc);
      out_carry = carry;
   end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Command sequencer and accumulator sitting directly upstream of `alu_4bit`. It accepts one opcode/operand command at a time over a valid/ready handshake and drives the ALU's `a`, `b` and `sel` inputs. It writes the ALU's 5-bit `result` back into a 4-bit accumulator and returns the accumulator plus zero/carry flags over a second valid/ready handshake. It also sequences a multi-cycle multiply that the combinational ALU cannot do alone.

## Interface
Parameters:
- `MUL_STEPS`, default 4: number of shift-add iterations for MUL. Fixed to the operand width; no other value is supported.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  a command is presented.
- `in_ready`  out  1  the block can accept a command; high only in IDLE.
- `in_op`  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 LOAD, 101 CLR, 110 MUL, 111 NOP.
- `in_operand`  in  4  operand B (or the LOAD value).
- `out_valid`  out  1  response available; high only in RESP.
- `out_ready`  in  1  the consumer accepts the response.
- `out_acc`  out  4  accumulator value.
- `out_zero`  out  1  high when `out_acc == 0`.
- `out_carry`  out  1  carry, borrow or overflow of the last command.

## Operation
- Handshake: a transfer occurs on an edge where valid and ready are both high. Upstream holds `in_op`/`in_operand` stable while `in_valid` is high without `in_ready`.
- FSM states: IDLE, EXEC, MUL, RESP.
  - IDLE: `in_ready=1`. On accept, latch op and operand; go to MUL if op is 110, otherwise EXEC.
  - EXEC: one cycle. Drive ALU `a=acc`, `b=operand`, `sel=op[1:0]`. Update acc and flags; go to RESP.
  - MUL: `MUL_STEPS` cycles. Form an internal 8-bit shift-add product of `acc*operand`. On the last step: `acc = product[3:0]`, `carry = |product[7:4]`; go to RESP.
  - RESP: `out_valid=1`; outputs stable. On `out_ready`, go to IDLE.
- Arithmetic and width rules:
  - ADD: `acc = result[3:0]`, `carry = result[4]`.
  - SUB: `acc = result[3:0]`, `carry = result[4]` (borrow; 1-2 gives acc 1111, carry 1).
  - AND / OR: `carry = 0`.
  - LOAD: `acc = operand`, `carry = 0`.
  - CLR: `acc = 0`, `carry = 0`.
  - NOP: acc unchanged, `carry = 0`. NOP still produces a response.
- `out_zero` is always derived from the updated acc.
- Only one command is in flight at a time; no new command is accepted until the response is taken.
- `in_valid` in a non-IDLE state is ignored and never latched.

## Timing
- Reset (async assert, sync release by flop): state IDLE, acc 0, `out_acc=0`, `out_zero=1`, `out_carry=0`, `out_valid=0`, `in_ready=1`.
- Latency from the accept edge to `out_valid` high:
  - 2 cycles for non-MUL ops (EXEC, then RESP).
  - `MUL_STEPS+1` = 5 cycles for MUL.
- Throughput: at most one command per 3 cycles (non-MUL, `out_ready` held high).
- RESP with `out_ready=1` in its first cycle returns to IDLE on the next edge. `in_ready` rises in that next cycle; there is no accept in the same cycle as the response transfer.
- `out_ready` held low keeps RESP indefinitely; acc, flags and `out_valid` are held.
- Reset mid-EXEC or mid-MUL aborts the command: no response, acc 0.
- Acc wrap-around is silent modulo 16; only `out_carry` reports it.

## Structure
- Shared package `alu_pkg`: opcode localparams (AND, OR, ADD, SUB, LOAD, CLR, MUL, NOP), FSM state encoding, and widths (data 4, result 5).
- Sub-module: one `alu_4bit` instance for EXEC. The MUL shift-add stays inline in this block.

## Test plan
- Reset, then LOAD 0011, then ADD 0101 → responses acc 0011 / carry 0, then acc 1000 / carry 0 / zero 0. Each `out_valid` rises 2 cycles after the accept.
- LOAD 1111, then ADD 0001 → acc 0000, carry 1, zero 1.
- LOAD 0001, then SUB 0010 → acc 1111, carry 1 (borrow).
- LOAD 1100, then AND 1010 → acc 1000; then OR 0011 → acc 1011, carry 0.
- LOAD 0101, then MUL 0011 → acc 1111, carry 0, `out_valid` 5 cycles after accept. Then MUL 0010 → acc 1110, carry 1 (product 30).
- Hold `out_ready` low 6 cycles while toggling `in_valid` → `in_ready` stays 0, outputs held, no extra command latched. Reset asserted mid-MUL → no response, acc 0, `out_zero` 1.
